seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display. Accepts a packed nibble word, decodes each nibble to active-low segments, and scans the digits one at a time at a programmable refresh rate. It adds hex decoding, per-digit decimal points, leading-zero blanking, anti-ghosting guard time and frame-synchronous (tear-free) value updates. Sits between the counter/datapath logic and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of digits scanned; ≥1.
- REFRESH_DIV, 50000: clk cycles per digit slot; ≥2.
- GUARD, 2: cycles at the start of each slot with all anodes off; 0 ≤ GUARD < REFRESH_DIV.
- HEX_EN, 1: 1 = nibbles A–F shown as hex glyphs; 0 = nibbles >9 blank.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  packed nibbles; digit 0 = value[3:0] = rightmost (least significant).
- dp_in  in  DIGITS  per-digit decimal point request, 1 = lit; sampled with value.
- blank_lz  in  1  1 = leading-zero blanking enabled; sampled with value.
- load  in  1  one-cycle strobe; captures value, dp_in, blank_lz.
- seg  out  8  {a,b,c,d,e,f,g,dp}, active low (0 = segment on), registered.
- an  out  DIGITS  anode enables, active low, one-hot-low or all-ones, registered.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

## Operation
- Pending register: load=1 copies value/dp_in/blank_lz into pending and sets pend_v. A later load before the frame boundary overwrites pending (last load wins).
- Shadow register (displayed data) updates only at the frame boundary (slot counter terminal and digit index = DIGITS-1): from the inputs directly if load=1 that cycle, else from pending if pend_v=1; pend_v clears. No update otherwise. The displayed frame never mixes old and new data.
- Slot counter cnt counts 0..REFRESH_DIV-1 and wraps; on wrap, digit index idx increments 0..DIGITS-1 and wraps to 0.
- Decode (active low, bit 7 = a): 0=0000001x, 1=1001111x, 2=0010010x, 3=0000110x, 4=1001100x, 5=0100100x, 6=0100000x, 7=0001111x, 8=0000000x, 9=0000100x, A=0001000x, b=1100000x, C=0110001x, d=1000010x, E=0110000x, F=0111000x; x = dp bit = ~dp for that digit. HEX_EN=0: nibbles 10–15 give seg[7:1]=1111111 (dp still honoured).
- Leading-zero blanking (shadow blank_lz=1): digit i is blanked (seg[7:1]=1111111) if it and all higher digits are 0. Digit 0 is never blanked. The dp bit is unaffected by blanking.
- Guard: while cnt < GUARD, an = all ones and seg = 8'hFF. Otherwise an has bit idx = 0 and all other bits = 1, and seg = the decoded shadow digit idx.
- frame_done = 1 for exactly the cycle following the frame boundary (aligned with the output registers).

## Timing
- Reset (rst=1 at a clk edge): cnt=0, idx=0, shadow=0, pending=0, pend_v=0, an=all ones, seg=8'hFF, frame_done=0. Applies mid-frame and overrides a simultaneous load.
- seg/an/frame_done are registered: they reflect cnt/idx/shadow from the previous cycle (1-cycle latency).
- Each digit is driven for REFRESH_DIV-GUARD cycles per frame. The frame period is DIGITS*REFRESH_DIV cycles.
- Load-to-display latency: from the load cycle to the next frame boundary, plus 1 cycle. At most DIGITS*REFRESH_DIV+1 cycles.
- DIGITS=1: idx is constant 0, and every slot end is a frame boundary.

## Test plan
- DIGITS=4, REFRESH_DIV=8, GUARD=2. Reset, then load 16'h1234, dp_in=0, blank_lz=0 → after the first frame boundary: slot 0 an=1110 seg=10011001; slot 1 an=1101 seg=00001101; slot 2 an=1011 seg=00100101; slot 3 an=0111 seg=10011111. Each slot shows an=1111 seg=FF for 2 cycles, then the digit for 6 cycles. frame_done pulses every 32 cycles.
- Load 16'h0050, blank_lz=1, dp_in=4'b0010 → digit3 and digit2 blank (seg=FF); digit1 seg=01001000; digit0 seg=00000011. Load 16'h0000 → only digit0 shows 00000011.
- HEX_EN=1: load 16'hAbCF → A=00010001, b=11000001, C=01100011, F=01110001. HEX_EN=0 with the same value → all four digits seg=FF.
- Load 16'h1111 mid-frame, then load 16'h2222 before the boundary → the current frame keeps the old data. The next frame shows 2 on all digits (seg=00100101); 1 is never shown.
- Load asserted in the exact boundary cycle with 16'h9999 → the next frame shows 00001001 on all digits.
- Assert rst for 1 cycle in the middle of slot 2 → the next cycle gives an=1111, seg=FF, frame_done=0. Scanning restarts at digit 0, slot cnt 0, with shadow=0 (blank_lz=0 shows 00000011).

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver
// Hex decode, per-digit dp, leading-zero blanking, guard time, frame-synchronous updates.
module seven_seg_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2,
   parameter int HEX_EN      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   input  logic                  load,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   pend_val, shd_val;
   logic [DIGITS-1:0]     pend_dp, shd_dp;
   logic                  pend_lz, shd_lz, pend_v;
   logic                  slot_end, boundary, in_guard, zero_above;
   logic [DIGITS-1:0]     lz_blank;
   logic [3:0]            nib;
   logic [7:0]            seg_next;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'b0000001;
         4'h1: glyph = 7'b1001111;
         4'h2: glyph = 7'b0010010;
         4'h3: glyph = 7'b0000110;
         4'h4: glyph = 7'b1001100;
         4'h5: glyph = 7'b0100100;
         4'h6: glyph = 7'b0100000;
         4'h7: glyph = 7'b0001111;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0000100;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b1100000;
         4'hC: glyph = 7'b0110001;
         4'hD: glyph = 7'b1000010;
         4'hE: glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
   endfunction

   assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
   assign boundary = slot_end && (idx == IW'(DIGITS - 1));
   assign in_guard = ({1'b0, cnt} < (CW + 1)'(GUARD));

   // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      zero_above = 1'b1;
      lz_blank   = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above  = zero_above & (shd_val[4*i +: 4] == 4'h0);
         lz_blank[i] = shd_lz & zero_above;
      end
   end

   always_comb begin
      nib      = shd_val[4*idx +: 4];
      seg_next = {glyph(nib), ~shd_dp[idx]};
      if (lz_blank[idx] || (HEX_EN == 0 && nib > 4'd9))
         seg_next[7:1] = 7'h7F;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_lz    <= 1'b0;
         pend_v     <= 1'b0;
         shd_val    <= '0;
         shd_dp     <= '0;
         shd_lz     <= 1'b0;
         an         <= '1;
         seg        <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pend_lz  <= blank_lz;
            pend_v   <= 1'b1;
         end
         // Shadow only changes between frames so a frame never mixes old and new data.
         if (boundary) begin
            if (load) begin
               shd_val <= value;
               shd_dp  <= dp_in;
               shd_lz  <= blank_lz;
            end else if (pend_v) begin
               shd_val <= pend_val;
               shd_dp  <= pend_dp;
               shd_lz  <= pend_lz;
            end
            pend_v <= 1'b0;
         end
         frame_done <= boundary;
         if (in_guard) begin
            an  <= '1;
            seg <= 8'hFF;
         end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_next;
         end
      end
   end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - self-checking bench for seven_seg_scan_driver
// Frame-level reference model plus directed scenarios and randomized loads.
module tb_seven_seg_scan_driver;
   localparam int DIG = 4;
   localparam int RD  = 8;
   localparam int GD  = 2;
   localparam int FRM = DIG * RD;

   logic clk = 1'b0;
   logic rst, load, blank_lz;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [7:0]  seg, seg_nh;
   logic [3:0]  an, an_nh;
   logic        frame_done, fd_nh;

   int checks = 0;
   int errors = 0;

   seven_seg_scan_driver #(.DIGITS(DIG), .REFRESH_DIV(RD), .GUARD(GD), .HEX_EN(1)) dut (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
      .load(load), .seg(seg), .an(an), .frame_done(frame_done));

   seven_seg_scan_driver #(.DIGITS(DIG), .REFRESH_DIV(RD), .GUARD(GD), .HEX_EN(0)) dut_nh (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
      .load(load), .seg(seg_nh), .an(an_nh), .frame_done(fd_nh));

   always #5 clk = ~clk;

   logic [6:0] glyph_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [3:0] d,
                                          input logic lz, input int dig, input bit hex);
      logic [3:0] n;
      logic [6:0] g;
      n = 4'((v >> (4*dig)) & 16'hF);
      g = (hex || n < 4'd10) ? glyph_tab[n] : 7'h7F;
      if (lz && dig > 0 && (v >> (4*dig)) == 16'h0) g = 7'h7F;
      return {g, ~d[dig]};
   endfunction

   // Reference: t = clk edges since reset; displayed data swaps at the end of each frame.
   int          t;
   logic [15:0] m_val, p_val;
   logic [3:0]  m_dp, p_dp;
   logic        m_lz, p_lz, p_v;
   logic [3:0]  e_an;
   logic [7:0]  e_seg, e_seg_nh;
   logic        e_fd;

   always @(posedge clk) begin
      if (rst) begin
         t <= 0;
         m_val <= '0; m_dp <= '0; m_lz <= 1'b0;
         p_val <= '0; p_dp <= '0; p_lz <= 1'b0; p_v <= 1'b0;
         e_an <= 4'hF; e_seg <= 8'hFF; e_seg_nh <= 8'hFF; e_fd <= 1'b0;
      end else begin
         if ((t % RD) < GD) begin
            e_an <= 4'hF; e_seg <= 8'hFF; e_seg_nh <= 8'hFF;
         end else begin
            e_an     <= ~(4'b0001 << ((t / RD) % DIG));
            e_seg    <= ref_seg(m_val, m_dp, m_lz, (t / RD) % DIG, 1'b1);
            e_seg_nh <= ref_seg(m_val, m_dp, m_lz, (t / RD) % DIG, 1'b0);
         end
         e_fd <= ((t % FRM) == FRM - 1);
         if (load) begin
            p_val <= value; p_dp <= dp_in; p_lz <= blank_lz; p_v <= 1'b1;
         end
         if ((t % FRM) == FRM - 1) begin
            if (load) begin
               m_val <= value; m_dp <= dp_in; m_lz <= blank_lz;
            end else if (p_v) begin
               m_val <= p_val; m_dp <= p_dp; m_lz <= p_lz;
            end
            p_v <= 1'b0;
         end
         t <= t + 1;
      end
   end

   function automatic bit matches_model();
      return an === e_an && seg === e_seg && frame_done === e_fd &&
             an_nh === e_an && seg_nh === e_seg_nh && fd_nh === e_fd;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
      value = v; dp_in = d; blank_lz = lz; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Recorder only: waits for the next frame end, then captures one sample per slot.
   logic [7:0] got_seg [4];
   logic [7:0] got_nh [4];
   logic [3:0] got_an [4];
   logic       got_fd, timeout, seen_one;
   int         mism;

   task automatic run_frame();
      int n;
      n = 0; mism = 0; timeout = 1'b0; seen_one = 1'b0;
      while (frame_done !== 1'b1 && n < FRM + 8) begin
         tick(); n++;
         if (!matches_model()) mism++;
      end
      if (frame_done !== 1'b1) timeout = 1'b1;
      for (int k = 1; k <= FRM; k++) begin
         tick();
         if (!matches_model()) mism++;
         if (seg[7:1] == 7'b1001111 && an != 4'hF) seen_one = 1'b1;
         if (k % RD == 5) begin
            got_seg[(k-1)/RD] = seg; got_nh[(k-1)/RD] = seg_nh; got_an[(k-1)/RD] = an;
         end
      end
      got_fd = frame_done;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; value = 16'hFFFF;
      tick(); tick();
      checks++;
      if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0 || seg_nh !== 8'hFF) begin
         errors++;
         $display("FAIL reset_state an=%b seg=%b fd=%b want 1111 11111111 0", an, seg, frame_done);
      end
      load = 1'b0; value = '0; rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (an !== 4'b1110 || seg !== 8'b00000011) begin
         errors++;
         $display("FAIL reset_shadow_zero an=%b seg=%b want 1110 00000011", an, seg);
      end
   endtask

   task automatic test_basic();
      do_load(16'h1234, 4'b0000, 1'b0);
      run_frame();
      checks++;
      if (timeout || mism != 0) begin
         errors++;
         $display("FAIL basic_model timeout=%b mismatches=%0d want 0 0", timeout, mism);
      end
      checks++;
      if (got_an[0] !== 4'b1110 || got_seg[0] !== 8'b10011001 ||
          got_an[1] !== 4'b1101 || got_seg[1] !== 8'b00001101 ||
          got_an[2] !== 4'b1011 || got_seg[2] !== 8'b00100101 ||
          got_an[3] !== 4'b0111 || got_seg[3] !== 8'b10011111) begin
         errors++;
         $display("FAIL basic_1234 seg=%b %b %b %b an=%b %b %b %b", got_seg[0], got_seg[1],
                  got_seg[2], got_seg[3], got_an[0], got_an[1], got_an[2], got_an[3]);
      end
      checks++;
      if (got_fd !== 1'b1) begin
         errors++;
         $display("FAIL frame_period fd=%b want 1 after %0d cycles", got_fd, FRM);
      end
   endtask

   task automatic test_blanking();
      do_load(16'h0050, 4'b0010, 1'b1);
      run_frame();
      checks++;
      if (timeout || mism != 0 || got_seg[3] !== 8'hFF || got_seg[2] !== 8'hFF ||
          got_seg[1] !== 8'b01001000 || got_seg[0] !== 8'b00000011) begin
         errors++;
         $display("FAIL blank_0050 mism=%0d seg3..0=%b %b %b %b want FF FF 01001000 00000011",
                  mism, got_seg[3], got_seg[2], got_seg[1], got_seg[0]);
      end
      do_load(16'h0000, 4'b0000, 1'b1);
      run_frame();
      checks++;
      if (timeout || mism != 0 || got_seg[3] !== 8'hFF || got_seg[2] !== 8'hFF ||
          got_seg[1] !== 8'hFF || got_seg[0] !== 8'b00000011) begin
         errors++;
         $display("FAIL blank_0000 mism=%0d seg3..0=%b %b %b %b want FF FF FF 00000011",
                  mism, got_seg[3], got_seg[2], got_seg[1], got_seg[0]);
      end
   endtask

   task automatic test_hex();
      do_load(16'hABCF, 4'b0000, 1'b0);
      run_frame();
      checks++;
      if (timeout || mism != 0 || got_seg[3] !== 8'b00010001 || got_seg[2] !== 8'b11000001 ||
          got_seg[1] !== 8'b01100011 || got_seg[0] !== 8'b01110001) begin
         errors++;
         $display("FAIL hex_glyphs mism=%0d seg3..0=%b %b %b %b", mism,
                  got_seg[3], got_seg[2], got_seg[1], got_seg[0]);
      end
      checks++;
      if (got_nh[3] !== 8'hFF || got_nh[2] !== 8'hFF || got_nh[1] !== 8'hFF || got_nh[0] !== 8'hFF) begin
         errors++;
         $display("FAIL hex_disabled seg3..0=%b %b %b %b want all FF",
                  got_nh[3], got_nh[2], got_nh[1], got_nh[0]);
      end
   endtask

   task automatic test_overwrite();
      repeat (10) tick();
      do_load(16'h1111, 4'b0000, 1'b0);
      repeat (3) tick();
      do_load(16'h2222, 4'b0000, 1'b0);
      run_frame();
      checks++;
      if (timeout || mism != 0 || seen_one) begin
         errors++;
         $display("FAIL overwrite_tear mism=%0d seen_one=%b want 0 0", mism, seen_one);
      end
      checks++;
      if (got_seg[0] !== 8'b00100101 || got_seg[1] !== 8'b00100101 ||
          got_seg[2] !== 8'b00100101 || got_seg[3] !== 8'b00100101) begin
         errors++;
         $display("FAIL overwrite_last_wins seg0..3=%b %b %b %b want 00100101",
                  got_seg[0], got_seg[1], got_seg[2], got_seg[3]);
      end
   endtask

   task automatic test_boundary_load();
      int n;
      n = 0;
      while ((t % FRM) != FRM - 1 && n < FRM + 4) begin tick(); n++; end
      do_load(16'h9999, 4'b0000, 1'b0);
      run_frame();
      checks++;
      if (timeout || mism != 0 || got_seg[0] !== 8'b00001001 || got_seg[1] !== 8'b00001001 ||
          got_seg[2] !== 8'b00001001 || got_seg[3] !== 8'b00001001) begin
         errors++;
         $display("FAIL boundary_load mism=%0d seg0..3=%b %b %b %b want 00001001",
                  mism, got_seg[0], got_seg[1], got_seg[2], got_seg[3]);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      n = 0;
      while ((t % FRM) != 2*RD + 3 && n < FRM + 4) begin tick(); n++; end
      rst = 1'b1;
      tick();
      checks++;
      if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset an=%b seg=%b fd=%b want 1111 11111111 0", an, seg, frame_done);
      end
      rst = 1'b0;
      repeat (4) tick();
      checks++;
      if (an !== 4'b1110 || seg !== 8'b00000011 || !matches_model()) begin
         errors++;
         $display("FAIL mid_reset_restart an=%b seg=%b want 1110 00000011", an, seg);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1200; i++) begin
         load     = ($urandom_range(0, 14) == 0);
         value    = 16'($urandom);
         if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
         dp_in    = 4'($urandom);
         blank_lz = 1'($urandom);
         rst      = ($urandom_range(0, 499) == 0);
         tick();
         checks++;
         if (!matches_model()) begin
            errors++;
            $display("FAIL random t=%0d an=%b/%b seg=%b/%b nh=%b/%b fd=%b/%b (got/want)",
                     t, an, e_an, seg, e_seg, seg_nh, e_seg_nh, frame_done, e_fd);
         end
      end
      load = 1'b0; rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
      repeat (3) tick();
      test_reset();
      test_basic();
      test_blanking();
      test_hex();
      test_overwrite();
      test_boundary_load();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
